// File: rtl/urv_pipe_pkg.sv
// Shared types and helpers for the uRV pipeline stall/kill controller.
// Holds the FSM state encoding and a stage-range reduction-OR.
package urv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } pipe_state_t;

  // Widest pipeline the range helper accepts; narrower vectors are zero-extended.
  localparam int MAX_STAGES = 64;

  // OR of vec[hi:lo]; an empty range (lo > hi) yields 0.
  function automatic logic range_or(input logic [MAX_STAGES-1:0] vec,
                                    input int lo, input int hi);
    logic r;
    r = 1'b0;
    for (int k = 0; k < MAX_STAGES; k++) begin
      if (k >= lo && k <= hi) r = r | vec[k];
    end
    return r;
  endfunction

endpackage

// File: rtl/urv_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module urv_sat_counter #(
  parameter int g_width = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [g_width-1:0] cnt_o
);

  logic [g_width-1:0] cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (clr_i) begin
      cnt_reg <= '0;
    end else if (inc_i && (cnt_reg != {g_width{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt_o = cnt_reg;

endmodule

// File: rtl/urv_pipe_ctrl.sv
// N-stage pipeline stall/kill controller: branch-shadow kill, trap redirect,
// debug halt/drain FSM with timeout and saturating performance counters.
module urv_pipe_ctrl
  import urv_pipe_pkg::*;
#(
  parameter int g_num_stages    = 4,
  parameter int g_branch_stage  = 2,
  parameter int g_drain_timeout = 64,
  parameter int g_cnt_width     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_num_stages-1:0] stall_req_i,
  input  logic [g_num_stages-1:0] stage_valid_i,
  input  logic                    bra_i,
  input  logic                    trap_i,
  input  logic                    halt_req_i,
  input  logic                    resume_i,
  input  logic                    cnt_clr_i,
  output logic [g_num_stages-1:0] stall_o,
  output logic [g_num_stages-1:0] kill_o,
  output logic                    halted_o,
  output logic                    halt_timeout_o,
  output logic [g_cnt_width-1:0]  stall_cnt_o,
  output logic [g_cnt_width-1:0]  redir_cnt_o
);

  localparam int N  = g_num_stages;
  localparam int B  = g_branch_stage;
  localparam int DW = $clog2(g_drain_timeout) + 1;

  pipe_state_t   state_reg, state_next;
  logic [B-1:0]  sh_reg, sh_next;
  logic [DW-1:0] drain_cnt_reg;
  logic          halt_timeout_reg, halt_timeout_next;
  logic [N-1:0]  base_stall, base_kill;
  logic          redir;
  logic          unused_valid0;

  assign redir         = bra_i | trap_i;
  assign unused_valid0 = stage_valid_i[0];

  // Younger stages stall behind any older request; stages below B bubble instead of self-stalling.
  for (genvar gi = 0; gi < N; gi++) begin : g_stall
    if (gi >= B) begin : g_self
      assign base_stall[gi] = range_or(MAX_STAGES'(stall_req_i), gi + 1, N - 1) | stall_req_i[gi];
    end else begin : g_noself
      assign base_stall[gi] = range_or(MAX_STAGES'(stall_req_i), gi + 1, N - 1);
    end
  end

  // sh[k] marks a redirect that happened k+1 advances ago; it kills everything younger than it.
  for (genvar gi = 0; gi < N; gi++) begin : g_kill
    if (gi == 0) begin : g_fetch
      assign base_kill[gi] = redir;
    end else if (gi <= B) begin : g_shadow
      assign base_kill[gi] = redir | range_or(MAX_STAGES'(sh_reg), 0, gi - 1);
    end else begin : g_old
      assign base_kill[gi] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < B; gi++) begin : g_sh
    if (gi == 0) begin : g_head
      assign sh_next[gi] = redir;
    end else begin : g_tail
      assign sh_next[gi] = sh_reg[gi-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg        <= ST_RUN;
      sh_reg           <= '0;
      drain_cnt_reg    <= '0;
      halt_timeout_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      halt_timeout_reg <= halt_timeout_next;
      if (!stall_o[B]) sh_reg <= sh_next;
      if (state_reg == ST_DRAIN) drain_cnt_reg <= drain_cnt_reg + 1'b1;
      else                       drain_cnt_reg <= '0;
    end
  end

  always_comb begin
    state_next        = state_reg;
    halt_timeout_next = halt_timeout_reg;
    case (state_reg)
      ST_RUN: begin
        if (halt_req_i && !redir) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((stage_valid_i[N-1:1] == '0) && (sh_reg == '0)) begin
          state_next        = ST_HALTED;
          halt_timeout_next = 1'b0;
        end else if (drain_cnt_reg == DW'(g_drain_timeout - 1)) begin
          state_next        = ST_HALTED;
          halt_timeout_next = 1'b1;
        end else if (!halt_req_i) begin
          state_next = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (resume_i) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    stall_o  = base_stall;
    kill_o   = base_kill;
    halted_o = 1'b0;
    case (state_reg)
      ST_DRAIN: begin
        stall_o[0] = 1'b1;
        kill_o[0]  = 1'b1;
      end
      ST_HALTED: begin
        stall_o  = '1;
        halted_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign halt_timeout_o = halt_timeout_reg;

  urv_sat_counter #(.g_width(g_cnt_width)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i ((state_reg == ST_RUN) && stall_o[0]),
    .clr_i (cnt_clr_i),
    .cnt_o (stall_cnt_o)
  );

  urv_sat_counter #(.g_width(g_cnt_width)) u_redir_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (redir && !stall_o[B]),
    .clr_i (cnt_clr_i),
    .cnt_o (redir_cnt_o)
  );

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Directed and randomized checks of urv_pipe_ctrl against a behavioural model;
// a second instance with 4-bit counters exercises saturation.
module tb_urv_pipe_ctrl;

  localparam int N = 4;
  localparam int B = 2;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] stall_req, stage_valid;
  logic         bra, trap, halt_req, resume, cnt_clr;

  logic [N-1:0] stall_o, kill_o, s4_stall_o, s4_kill_o;
  logic         halted, hto, s4_halted, s4_hto;
  logic [31:0]  stall_cnt, redir_cnt;
  logic [3:0]   s4_stall_cnt, s4_redir_cnt;

  urv_pipe_ctrl #(.g_num_stages(N), .g_branch_stage(B), .g_drain_timeout(T), .g_cnt_width(32)) dut (
    .clk_i(clk), .rst_i(rst), .stall_req_i(stall_req), .stage_valid_i(stage_valid),
    .bra_i(bra), .trap_i(trap), .halt_req_i(halt_req), .resume_i(resume), .cnt_clr_i(cnt_clr),
    .stall_o(stall_o), .kill_o(kill_o), .halted_o(halted), .halt_timeout_o(hto),
    .stall_cnt_o(stall_cnt), .redir_cnt_o(redir_cnt)
  );

  urv_pipe_ctrl #(.g_num_stages(N), .g_branch_stage(B), .g_drain_timeout(T), .g_cnt_width(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .stall_req_i(stall_req), .stage_valid_i(stage_valid),
    .bra_i(bra), .trap_i(trap), .halt_req_i(halt_req), .resume_i(resume), .cnt_clr_i(cnt_clr),
    .stall_o(s4_stall_o), .kill_o(s4_kill_o), .halted_o(s4_halted), .halt_timeout_o(s4_hto),
    .stall_cnt_o(s4_stall_cnt), .redir_cnt_o(s4_redir_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: mode 0=running, 1=draining, 2=halted.
  int           m_mode;
  int           m_drain_cycles;
  logic         m_timeout;
  int           m_ages[$];
  int           m_stall_raw, m_redir_raw;
  logic [N-1:0] exp_stall, exp_kill;
  logic         exp_halted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat4(input int raw);
    return (raw > 15) ? 15 : raw;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_drain_cycles = 0; m_timeout = 1'b0;
    m_ages.delete();
    m_stall_raw = 0; m_redir_raw = 0;
  endtask

  task automatic model_comb();
    int   h;
    logic redir, shadow;
    h = -1;
    for (int j = 0; j < N; j++) if (stall_req[j]) h = j;
    redir = bra | trap;
    for (int i = 0; i < N; i++) begin
      exp_stall[i] = (h > i) || (i >= B && h >= i);
      shadow = 1'b0;
      foreach (m_ages[k]) if (m_ages[k] <= i) shadow = 1'b1;
      if (i == 0)       exp_kill[i] = redir;
      else if (i <= B)  exp_kill[i] = redir | shadow;
      else              exp_kill[i] = 1'b0;
    end
    if (m_mode == 1) begin exp_stall[0] = 1'b1; exp_kill[0] = 1'b1; end
    if (m_mode == 2) exp_stall = '1;
    exp_halted = (m_mode == 2);
  endtask

  task automatic model_next();
    logic redir, advance;
    int   aged[$];
    redir   = bra | trap;
    advance = !exp_stall[B];
    if (cnt_clr) begin
      m_stall_raw = 0; m_redir_raw = 0;
    end else begin
      if (m_mode == 0 && exp_stall[0]) m_stall_raw++;
      if (redir && advance) m_redir_raw++;
    end
    case (m_mode)
      0: if (halt_req && !redir) begin m_mode = 1; m_drain_cycles = 0; end
      1: begin
        if ((stage_valid >> 1) == 0 && m_ages.size() == 0) begin m_mode = 2; m_timeout = 1'b0; end
        else if (m_drain_cycles == T - 1) begin m_mode = 2; m_timeout = 1'b1; end
        else if (!halt_req) m_mode = 0;
        else m_drain_cycles++;
      end
      default: if (resume) m_mode = 0;
    endcase
    if (advance) begin
      foreach (m_ages[k]) if (m_ages[k] + 1 <= B) aged.push_back(m_ages[k] + 1);
      if (redir) aged.push_back(1);
      m_ages = aged;
    end
  endtask

  // Compare every output against the model for the current cycle, then clock it.
  task automatic tick();
    #1;
    model_comb();
    check("stall_o", stall_o, exp_stall);
    check("kill_o", kill_o, exp_kill);
    check("halted_o", halted, exp_halted);
    check("halt_timeout_o", hto, m_timeout);
    check("stall_cnt_o", stall_cnt, m_stall_raw);
    check("redir_cnt_o", redir_cnt, m_redir_raw);
    check("w4_stall_o", s4_stall_o, exp_stall);
    check("w4_kill_o", s4_kill_o, exp_kill);
    check("w4_stall_cnt_o", s4_stall_cnt, sat4(m_stall_raw));
    check("w4_redir_cnt_o", s4_redir_cnt, sat4(m_redir_raw));
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_req = '0; stage_valid = '0; bra = 0; trap = 0;
    halt_req = 0; resume = 0; cnt_clr = 0;
  endtask

  // Reset asserted between edges must take effect before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_stall"}, stall_o, 4'b0000);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_cnt"}, stall_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", stall_o, 4'b0000);
    check("reset_kill", kill_o, 4'b0000);
    check("reset_halted", halted, 1'b0);
    check("reset_hto", hto, 1'b0);
    check("reset_cnt", stall_cnt, 0);
    rst = 1'b0;

    // Stall propagation
    stall_req = 4'b0100; #1 check("prop_0100", stall_o, 4'b0111); tick();
    stall_req = 4'b0010; #1 check("prop_0010", stall_o, 4'b0001); tick();
    stall_req = 4'b1000; #1 check("prop_1000", stall_o, 4'b1111); tick();
    stall_req = 4'b0000; tick();

    // Branch shadow with no stalls
    check("redir_cnt_before", redir_cnt, 0);
    bra = 1; #1 check("shadow_c0", kill_o, 4'b0111); tick();
    bra = 0; #1 check("shadow_c1", kill_o, 4'b0110); tick();
    #1 check("shadow_c2", kill_o, 4'b0100); tick();
    #1 check("shadow_c3", kill_o, 4'b0000);
    check("shadow_redir_cnt", redir_cnt, 1);
    tick();

    // Shadow holds while stage B is stalled
    bra = 1; tick();
    bra = 0; stall_req = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      #1 check("hold_kill2", kill_o[2], 1'b1);
      tick();
    end
    stall_req = 4'b0000;
    #1 check("hold_release", kill_o, 4'b0110); tick();
    #1 check("hold_resume", kill_o, 4'b0100); tick();
    tick();

    // Trap redirect
    trap = 1; #1 check("trap_kill", kill_o, 4'b0111); tick();
    trap = 0; #1 check("trap_shadow", kill_o, 4'b0110); tick();
    bra = 1; trap = 1; tick();
    bra = 0; trap = 0;
    repeat (3) tick();

    // Clean halt
    halt_req = 1; stage_valid = 4'b1110; tick();
    #1 check("drain_stall0", stall_o[0], 1'b1);
    check("drain_kill0", kill_o[0], 1'b1);
    repeat (3) tick();
    stage_valid = 4'b0000;
    n = 0;
    while (!halted && n < 4) begin tick(); n++; end
    check("clean_halt_reached", halted, 1'b1);
    check("clean_hto", hto, 1'b0);
    check("halted_stall", stall_o, 4'b1111);
    halt_req = 0; resume = 1; tick();
    resume = 0;
    check("resume_halted", halted, 1'b0);
    tick();

    // Timeout halt
    halt_req = 1; stage_valid = 4'b1110; tick();
    n = 0;
    while (!halted && n < 200) begin tick(); n++; end
    check("timeout_cycles", n, T);
    check("timeout_hto", hto, 1'b1);
    halt_req = 0; resume = 1; tick();
    resume = 0; stage_valid = 4'b0000; tick();

    // Saturation of the narrow counters
    cnt_clr = 1; tick();
    cnt_clr = 0; stall_req = 4'b0100;
    repeat (20) tick();
    check("sat_w4", s4_stall_cnt, 4'd15);
    check("sat_w32", stall_cnt, 20);
    stall_req = 4'b0000; cnt_clr = 1; tick();
    cnt_clr = 0;
    check("clr_w4", s4_stall_cnt, 4'd0);
    check("clr_w32", stall_cnt, 0);
    tick();

    // Asynchronous reset mid-DRAIN and mid-HALTED
    halt_req = 1; stage_valid = 4'b1110; tick(); tick();
    idle_inputs();
    async_reset("rst_drain");
    tick();
    halt_req = 1; tick(); tick();
    check("pre_rst_halted", halted, 1'b1);
    idle_inputs();
    async_reset("rst_halted");
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      stall_req   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      stage_valid = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      bra         = ($urandom_range(0, 7) == 0);
      trap        = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 19) == 0) halt_req = ~halt_req;
      resume      = ($urandom_range(0, 5) == 0);
      cnt_clr     = ($urandom_range(0, 39) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/urv_pipe_ctrl.md
Name: urv_pipe_ctrl

Overview:
- Parametrised pipeline stall/kill controller for uRV-class in-order cores.
- Generalises fixed F/D/X/W stall and branch-shadow kill logic to N stages with a configurable branch-resolve stage.
- Adds trap redirect, a debug halt/drain state machine with timeout, and saturating performance counters.
- Sits in the CPU top level between per-stage stall requests and per-stage stall/kill inputs.

Parameters:
- g_num_stages, 4: pipeline depth N (>=2); index 0 = fetch (youngest), N-1 = writeback (oldest).
- g_branch_stage, 2: stage B resolving branches/traps; 1 <= B <= N-2.
- g_drain_timeout, 64: max DRAIN cycles before forced halt (>=1).
- g_cnt_width, 32: performance counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- stall_req_i  in  N  per-stage stall request
- stage_valid_i  in  N  stage holds a valid instruction
- bra_i  in  1  branch taken at stage B
- trap_i  in  1  trap/exception redirect at stage B
- halt_req_i  in  1  debug halt request (level)
- resume_i  in  1  leave halt (pulse)
- cnt_clr_i  in  1  synchronous counter clear
- stall_o  out  N  per-stage stall
- kill_o  out  N  per-stage kill (invalidate)
- halted_o  out  1  core halted
- halt_timeout_o  out  1  sticky: last halt was forced by timeout
- stall_cnt_o  out  g_cnt_width  cycles with stall_o[0]=1 in RUN
- redir_cnt_o  out  g_cnt_width  redirects taken

Behaviour:
- Reset: shadow register=0, FSM=RUN, counters=0, halted_o=0, halt_timeout_o=0. stall_o/kill_o combinational; resolve to 0 when inputs idle.
- redir = bra_i | trap_i.
- Stall rule: base[i] = OR(stall_req_i[N-1:i+1]) | (i>=B ? stall_req_i[i] : 0). Stages below B do not self-stall; they bubble.
- Shadow: B-bit shift register sh[0..B-1]. When !stall_o[B]: sh[0]<=redir, sh[k]<=sh[k-1]. Otherwise holds.
- kill_o[0] = redir.
- kill_o[i] = redir | OR(sh[i-1:0]) for 1<=i<=B.
- kill_o[i] = 0 for i>B, except on trap_i, where kill_o[B]=1 and kill_o[B+1]=0.
- FSM RUN: stall_o=base. halt_req_i & !redir -> DRAIN. If redir is coincident, enter DRAIN next cycle.
- FSM DRAIN: stall_o[0] forced 1, kill_o[0] forced 1, other stalls = base. Drain counter increments each cycle.
  - stage_valid_i[N-1:1]==0 and sh==0 -> HALTED; halt_timeout_o<=0.
  - Drain counter == g_drain_timeout-1 -> HALTED; halt_timeout_o<=1.
  - halt_req_i deasserted -> RUN (abort).
- FSM HALTED: stall_o all 1, halted_o=1. resume_i -> RUN; halted_o=0 next cycle. resume_i is ignored outside HALTED.
- Counters saturate at all-ones and never wrap. cnt_clr_i has priority over increment.
  - stall_cnt_o increments when FSM=RUN and stall_o[0].
  - redir_cnt_o increments on redir & !stall_o[B].
- Simultaneous bra_i and trap_i count as one redirect; trap kill rule applies.
- Asynchronous reset mid-DRAIN or mid-HALTED returns to RUN immediately.

Decomposition:
- Package urv_pipe_pkg:
  - FSM state encoding ST_RUN=0, ST_DRAIN=1, ST_HALTED=2.
  - Function for reduction-OR of a stage range.
- Sub-module urv_sat_counter (width, inc, clr), instantiated twice.
- Shadow register and FSM stay in the top module.

Test Plan:
- Stall propagation: N=4, B=2, stall_req_i=4'b0100 -> stall_o=4'b0111. stall_req_i=4'b0010 -> stall_o=4'b0001.
- Branch shadow: bra_i one cycle, no stalls.
  - Cycle0: kill_o=4'b0111.
  - Cycle1: kill_o=4'b0110.
  - Cycle2: kill_o=4'b0100.
  - Cycle3: kill_o=0. redir_cnt_o=1.
- Shadow hold: bra_i then stall_req_i[3]=1 for 3 cycles -> kill_o[2] remains 1 throughout the stall; shadow resumes after release.
- Trap: trap_i pulse -> kill_o[2]=1, kill_o[3]=0; shadow behaves as for a branch.
- Clean halt: halt_req_i=1, stage_valid_i drops to 0 after 3 cycles.
  - HALTED within 4 cycles; halt_timeout_o=0; stall_o=4'b1111.
  - resume_i pulse -> halted_o=0 next cycle.
- Timeout halt and saturation:
  - stage_valid_i held 4'b1110 -> halted_o=1 exactly 64 cycles after DRAIN entry; halt_timeout_o=1.
  - Separately, g_cnt_width=4 with 20 stall cycles -> stall_cnt_o=15.
  - cnt_clr_i pulse -> 0.
